// File: rtl/retire_pkg.sv
// Shared types for the ROB retire path: head-entry layout and controller states.
package retire_pkg;

    localparam int unsigned RETIRE_XLEN = 32;
    localparam int unsigned ARF_ADDR_W  = 5;

    // ROB entry layout, MSB first; the ROB FIFO sizes its storage from this.
    typedef struct packed {
        logic                   done;
        logic                   exc;
        logic                   mispred;
        logic                   rd_we;
        logic [ARF_ADDR_W-1:0]  rd;
        logic [RETIRE_XLEN-1:0] result;
        logic [RETIRE_XLEN-1:0] target_pc;
    } rob_entry_t;

    localparam int unsigned ROB_ENTRY_W = $bits(rob_entry_t);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } retire_state_e;

endpackage

// File: rtl/rob_retire_ctrl.sv
// In-order retire controller: commits completed ROB head entries to the
// architectural register file and raises a held flush on mispredict/exception.
module rob_retire_ctrl
    import retire_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned N_ENTRIES = 8,
    parameter int unsigned CNT_W     = 32,
    localparam int unsigned PTR_W    = $clog2(N_ENTRIES),
    localparam int unsigned ENTRY_W  = 4 + ARF_ADDR_W + 2 * XLEN
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic                  head_valid,
    input  logic [ENTRY_W-1:0]    head_data,
    input  logic [PTR_W-1:0]      head_id,
    output logic                  head_ready,
    output logic                  arf_we,
    output logic [ARF_ADDR_W-1:0] arf_waddr,
    output logic [XLEN-1:0]       arf_wdata,
    output logic                  flush,
    output logic [XLEN-1:0]       flush_pc,
    input  logic                  flush_ack,
    input  logic [XLEN-1:0]       trap_vec,
    output logic                  exc_pulse,
    output logic [PTR_W-1:0]      exc_rob_id,
    output logic [CNT_W-1:0]      retire_count
);

    retire_state_e state, state_nxt;

    logic                  h_done, h_exc, h_mispred, h_rd_we;
    logic [ARF_ADDR_W-1:0] h_rd;
    logic [XLEN-1:0]       h_result, h_target;
    logic                  fire;

    assign {h_done, h_exc, h_mispred, h_rd_we, h_rd, h_result, h_target} = head_data;

    // Dequeue handshake and next-state selection.
    always_comb begin
        fire      = (state == RUN) && head_valid && h_done;
        state_nxt = state;
        unique case (state)
            RUN:   if (fire && (h_exc || h_mispred)) state_nxt = FLUSH;
            FLUSH: if (flush_ack)                     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign head_ready = fire;

    // State register.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) state <= RUN;
        else         state <= state_nxt;
    end

    // Registered commit, counter, exception and flush outputs (one cycle after the fire).
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            arf_we       <= 1'b0;
            arf_waddr    <= '0;
            arf_wdata    <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
            exc_pulse    <= 1'b0;
            exc_rob_id   <= '0;
            retire_count <= '0;
        end else begin
            arf_we    <= fire && !h_exc && h_rd_we && (h_rd != '0);
            exc_pulse <= fire && h_exc;
            if (fire && !h_exc) begin
                arf_waddr    <= h_rd;
                arf_wdata    <= h_result;
                retire_count <= retire_count + 1'b1;
            end
            if (fire && h_exc) begin
                exc_rob_id <= head_id;
                flush      <= 1'b1;
                flush_pc   <= trap_vec;
            end else if (fire && h_mispred) begin
                flush      <= 1'b1;
                flush_pc   <= h_target;
            end else if (state == FLUSH && flush_ack) begin
                flush      <= 1'b0;
            end
        end
    end

endmodule
